// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: PC register plus a DEPTH-entry circular queue of
// fetched {inst, pc+4} pairs feeding IF/ID through valid/ready.
// A redirect from ID loads a new PC and empties the queue in one cycle.
// Optional build macro FETCH_PERF_CNT_EN adds saturating performance counters.
module fetch_queue_unit #(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         redirect_valid,
  input  logic [WIDTH-1:0]             redirect_target,
  output logic [WIDTH-1:0]             imem_addr,
  input  logic [WIDTH-1:0]             imem_rdata,
  input  logic                         imem_ready,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_inst,
  output logic [WIDTH-1:0]             out_pc4,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   queue_count
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]                  perf_fetched,
  output logic [31:0]                  perf_flushed,
  output logic [31:0]                  perf_stall_cycles
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus4;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic             full;
  logic             push;
  logic             pop;

  logic [WIDTH-1:0] inst_q [DEPTH];
  logic [WIDTH-1:0] pc4_q  [DEPTH];

  assign pc_plus4    = pc + WIDTH'(4);
  assign full        = (count == DEPTH_C);
  assign out_valid   = (count != '0);
  assign pop         = out_valid & out_ready;
  // A pop in the same cycle frees the slot, so a full queue still streams.
  assign push        = imem_ready & (~full | pop) & ~redirect_valid;
  assign imem_addr   = pc;
  assign out_inst    = inst_q[rd_ptr];
  assign out_pc4     = pc4_q[rd_ptr];
  assign queue_count = count;

  // Occupancy after this cycle's push/pop (redirect handled in the register).
  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + CW'(1);
    end else if (!push && pop) begin
      count_next = count - CW'(1);
    end
  end

  // Queue storage; contents need no reset since out_valid gates them.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_q[wr_ptr] <= imem_rdata;
      pc4_q[wr_ptr]  <= pc_plus4;
    end
  end

  // PC, pointers and occupancy; redirect overrides any push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      pc     <= redirect_target;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc     <= pc_plus4;
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count_next;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [32:0] flushed_sum;

  assign flushed_sum = {1'b0, perf_flushed} + 33'(count);

  // Saturating event counters for fetches, flushed entries and full stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched      <= '0;
      perf_flushed      <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (push && perf_fetched != 32'hFFFF_FFFF) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (redirect_valid) begin
        perf_flushed <= flushed_sum[32] ? 32'hFFFF_FFFF : flushed_sum[31:0];
      end
      if (full && !pop && perf_stall_cycles != 32'hFFFF_FFFF) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
    end
  end
`endif

endmodule
